simt_scheduler: RTL

SIMT_SCHEDULER -- requirements
Module: simt_scheduler

---
 rtl/simt_pkg.sv | 23 ++
 rtl/pc_min_select.sv | 41 ++++
 rtl/simt_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/simt_pkg.sv
// simt_pkg: shared encodings for the SIMT block scheduler.
//   core_state_e    : scheduler state encoding, also driven on core_state
//   FETCHER_FETCHED : fetcher_state value meaning the instruction is ready
//   LSU_REQUESTING  : per-lane LSU state, request outstanding
//   LSU_WAITING     : per-lane LSU state, waiting for response
package simt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_REQUEST = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } core_state_e;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;
  localparam logic [1:0] LSU_REQUESTING  = 2'b01;
  localparam logic [1:0] LSU_WAITING     = 2'b10;

endpackage

// File: rtl/pc_min_select.sv
// pc_min_select: combinational selection of the next PC to execute.
// Finds the unsigned minimum PC over the live lanes and flags every live lane
// sitting at that PC, which is what makes divergent lanes reconverge.
//   live     : lanes still running
//   lane_pc  : per-lane program counters
//   min_pc   : smallest PC among live lanes (0 when no lane is live)
//   min_mask : live lanes whose PC equals min_pc
module pc_min_select #(
  parameter int LANES    = 4,
  parameter int PC_WIDTH = 8
) (
  input  logic [LANES-1:0]               live,
  input  logic [LANES-1:0][PC_WIDTH-1:0] lane_pc,
  output logic [PC_WIDTH-1:0]            min_pc,
  output logic [LANES-1:0]               min_mask
);

  logic [PC_WIDTH-1:0] best;
  logic                found;

  always_comb begin
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (live[i] && (!found || lane_pc[i] < best)) begin
        best  = lane_pc[i];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    min_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      min_mask[i] = live[i] && (lane_pc[i] == best);
    end
  end

  assign min_pc = best;

endmodule

// File: rtl/simt_scheduler.sv
// simt_scheduler: sequences one thread block through fetch/decode/memory/
// execute/update, tracking a PC and live bit per lane. Each instruction runs
// on the lanes sitting at the lowest live PC, so divergent lanes serialise and
// reconverge once their PCs match again.
//   clk, reset      : clock, synchronous active-high reset
//   start           : launch a block (sampled in IDLE only)
//   thread_count    : number of valid lanes, clamped to THREADS_PER_BLOCK
//   decoded_ret     : current instruction is RET
//   fetcher_state   : fetcher status, FETCHED releases FETCH
//   lsu_state       : per-lane LSU status, busy lanes stall WAIT
//   next_pc         : per-lane computed next PC, taken in UPDATE
//   current_pc      : PC being fetched/executed
//   active_mask     : lanes executing the current instruction
//   core_state      : current scheduler state
//   done            : block finished, held until reset
//   cycle_count     : busy-cycle counter (SIMT_SCHED_PERF_EN only, else 0)
//   instr_count     : retired-instruction counter (SIMT_SCHED_PERF_EN only)
// Build option: define SIMT_SCHED_PERF_EN to implement the perf counters.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | current_pc/active_mask valid, waiting for fetcher
// DECODE  | one cycle decode
// REQUEST | one cycle LSU request issue
// WAIT    | stall until no active lane has LSU busy
// EXECUTE | one cycle execute
// UPDATE  | commit next_pc or retire lanes on RET, pick next PC
// DONE    | block finished, sticky until reset
module simt_scheduler
  import simt_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]         thread_count,
  input  logic                                       decoded_ret,
  input  logic [2:0]                                 fetcher_state,
  input  logic [THREADS_PER_BLOCK-1:0][1:0]          lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0]                        current_pc,
  output logic [THREADS_PER_BLOCK-1:0]               active_mask,
  output logic [2:0]                                 core_state,
  output logic                                       done,
  output logic [31:0]                                cycle_count,
  output logic [31:0]                                instr_count
);

  localparam int T = THREADS_PER_BLOCK;

  core_state_e                state;
  logic [T-1:0]               live;
  logic [T-1:0][PC_WIDTH-1:0] thread_pc;

  // Lane state as it will be after this cycle's edge; the selector looks at
  // these so the PC chosen on FETCH entry reflects the update just made.
  logic [T-1:0]               nxt_live;
  logic [T-1:0][PC_WIDTH-1:0] nxt_pc;
  logic [T-1:0]               start_live;
  logic [PC_WIDTH-1:0]        sel_pc;
  logic [T-1:0]               sel_mask;
  logic                       lsu_busy;

  always_comb begin
    int tc;
    tc = int'(thread_count);
    if (tc > T) tc = T;
    start_live = '0;
    for (int i = 0; i < T; i++) begin
      start_live[i] = (i < tc);
    end
  end

  always_comb begin
    nxt_live = live;
    nxt_pc   = thread_pc;
    case (state)
      ST_IDLE: begin
        nxt_live = start_live;
        nxt_pc   = '0;
      end
      ST_UPDATE: begin
        if (decoded_ret) begin
          nxt_live = live & ~active_mask;
        end else begin
          for (int i = 0; i < T; i++) begin
            if (active_mask[i]) nxt_pc[i] = next_pc[i];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (active_mask[i] &&
          (lsu_state[i] == LSU_REQUESTING || lsu_state[i] == LSU_WAITING)) begin
        lsu_busy = 1'b1;
      end
    end
  end

  pc_min_select #(
    .LANES    (T),
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_min_select (
    .live     (nxt_live),
    .lane_pc  (nxt_pc),
    .min_pc   (sel_pc),
    .min_mask (sel_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      current_pc  <= '0;
      active_mask <= '0;
      done        <= 1'b0;
      live        <= '0;
      thread_pc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            live      <= nxt_live;
            thread_pc <= nxt_pc;
            if (start_live == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state       <= ST_FETCH;
              current_pc  <= sel_pc;
              active_mask <= sel_mask;
            end
          end
        end
        ST_FETCH: begin
          if (fetcher_state == FETCHER_FETCHED) state <= ST_DECODE;
        end
        ST_DECODE:  state <= ST_REQUEST;
        ST_REQUEST: state <= ST_WAIT;
        ST_WAIT: begin
          if (!lsu_busy) state <= ST_EXECUTE;
        end
        ST_EXECUTE: state <= ST_UPDATE;
        ST_UPDATE: begin
          live        <= nxt_live;
          thread_pc   <= nxt_pc;
          current_pc  <= sel_pc;
          active_mask <= sel_mask;
          if (nxt_live == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_DONE: done <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign core_state = state;

`ifdef SIMT_SCHED_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state != ST_IDLE && state != ST_DONE && cycle_q != 32'hFFFF_FFFF)
        cycle_q <= cycle_q + 32'd1;
      if (state == ST_UPDATE && instr_q != 32'hFFFF_FFFF)
        instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
